fp_mul_rr_sched: RTL and testbench
==================================

# fp_mul_rr_sched

Round-robin scheduler that shares one combinational `fp_mul` datapath (FP16×FP16→FP32 by default) among `NumReq` requesters. Each requester has its own valid/ready request channel and its own one-entry registered response slot. At most one operand pair is accepted per cycle, and each result returns to its issuing requester one cycle after acceptance. The block sits between the accelerator's operand streamers and the multiplier, and gives the multiplier registered-output timing and per-port back-pressure.

## Interface
Parameters:
- `NumReq`, 2: number of requester ports, ≥1.
- `FpFormat_a`, `fpnew_pkg::fp_format_e'(2)`: operand A format (FP16).
- `FpFormat_b`, `fpnew_pkg::fp_format_e'(2)`: operand B format (FP16).
- `FpFormat_out`, `fpnew_pkg::fp_format_e'(0)`: result format (FP32).
- `RndMode`, `fpnew_pkg::roundmode_e'(0)`: rounding mode forwarded to `fp_mul` (RNE).
- `WIDTH_a`, `WIDTH_b`, `WIDTH_out`: derived via `fpnew_pkg::fp_width`; do not override.

Ports:
- `clk_i`, in, 1: clock, rising edge.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `req_valid_i`, in, NumReq: operand pair valid, one bit per requester.
- `req_ready_o`, out, NumReq: operand pair accepted this cycle.
- `req_a_i`, in, NumReq×WIDTH_a: operand A, flattened, requester i at `[i*WIDTH_a +: WIDTH_a]`.
- `req_b_i`, in, NumReq×WIDTH_b: operand B, flattened the same way.
- `rsp_valid_o`, out, NumReq: result slot i holds a result.
- `rsp_ready_i`, in, NumReq: requester i consumes its result.
- `rsp_result_o`, out, NumReq×WIDTH_out: result slot contents, flattened.
- `cnt_clear_i`, in, 1: synchronous clear of `ops_cnt_o`.
- `ops_cnt_o`, out, 32: number of accepted operations.
- `busy_o`, out, 1: OR of all `rsp_valid_o` bits.

## Operation
- **Eligibility.** Requester i is eligible when `req_valid_i[i]` and its slot is free or draining this cycle: `!rsp_valid_q[i] || rsp_ready_i[i]`.
- **Arbitration.** The grant goes to the first eligible requester searching from `rr_ptr_q` upward, modulo NumReq. `req_ready_o` is one-hot or zero, equal to the grant. It depends combinationally on `req_valid_i` and `rsp_ready_i`.
- **Pointer update.** When a grant to g occurs, `rr_ptr_q <= (g+1) mod NumReq`. With no grant, the pointer holds. Its width is `max(1,$clog2(NumReq))`.
- **Datapath.** The granted requester's A/B are muxed into a single `fp_mul` instance. `operand_c_i` is tied to 0. When there is no grant the mux is driven with zeros and its output is ignored.
- **Slot write.** On grant g, `rsp_result_q[g] <= fp_mul result` and `rsp_valid_q[g] <= 1`.
- **Slot drain.** When `rsp_valid_o[i] && rsp_ready_i[i]` and no grant to i, `rsp_valid_q[i] <= 0`.
- **Drain and refill in the same cycle.** The slot loads the new result and valid stays 1. This is a lossless back-to-back stream.
- **Stability.** A slot that is valid and not ready holds its value and valid unchanged, and requester i is not granted.
- **Counter.** `ops_cnt_o` increments by 1 on every grant and wraps at 2^32. If `cnt_clear_i` and a grant occur in the same cycle, the counter becomes 1. A clear alone sets it to 0.
- **No internal state machine beyond the pointer.** Ordering within one requester is preserved trivially because that requester has at most one result in flight.

## Timing
- **Reset values.** `rsp_valid_o=0`, `rsp_result_o=0`, `ops_cnt_o=0`, `busy_o=0`, `rr_ptr_q=0`. `req_ready_o` is combinational and therefore 0 while all `rsp_valid_q` are 0 and no `req_valid_i` is high.
- **Latency.** Accept at edge T; `rsp_valid_o[g]` and the result are visible after edge T.
- **Throughput.** One operation per cycle aggregate. A single requester with `rsp_ready_i` held high sustains 1 operation per cycle.
- **Fairness.** With all NumReq requesters continuously eligible, grants rotate strictly 0,1,…,NumReq-1.
- **Reset mid-operation.** Asserting `rst_ni` low clears all slots and the pointer asynchronously. In-flight results are discarded.
- **Critical path.** Arbiter, then operand mux, then `fp_mul`, then slot register, all in one cycle. No internal pipelining.

## Test plan
- **Single requester, basic product.** Requester 0: A=0x3C00 (1.0), B=0x4000 (2.0), rsp_ready=1. Required: rsp_valid_o[0]=1 one cycle later with result 0x40000000. `ops_cnt_o`=1.
- **Sign and fairness.** Both requesters valid continuously with rsp_ready=1; requester 0 sends 0x3E00×0xC000, requester 1 sends 0x4000×0x4000. Required: grants alternate 0,1,0,1 starting at 0. Requester 0 results are 0xC0400000 (−3.0); requester 1 results are 0x40800000 (4.0).
- **Back-pressure.** Requester 0 valid with rsp_ready_i[0]=0 after its first result. Required: req_ready_o[0]=0 and the slot holds 0x40000000 stable. Meanwhile requester 1 is granted every cycle. Raising rsp_ready_i[0] re-grants requester 0 in that same cycle.
- **Special value.** A=0x7C00 (+inf), B=0x0000. Required: result 0x7FC00000 (qNaN).
- **Counter and reset.** 5 grants, then cnt_clear_i asserted together with a grant. Required: ops_cnt_o=1. Then assert rst_ni low while slots are valid. Required: all rsp_valid_o=0 and ops_cnt_o=0 immediately, and the first grant after release goes to requester 0.

Source files
------------

// File: rtl/fp_mul_rr_sched.sv
// Round-robin scheduler sharing one combinational FP multiplier among NumReq requesters,
// each with its own valid/ready request channel and one-entry registered result slot.

package fpnew_pkg;
  typedef enum logic [2:0] {FP32 = 3'd0, FP64 = 3'd1, FP16 = 3'd2, FP8 = 3'd3, FP16ALT = 3'd4} fp_format_e;
  typedef enum logic [2:0] {RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4} roundmode_e;

  function automatic int exp_bits(fp_format_e fmt);
    case (fmt)
      FP64:      return 11;
      FP16, FP8: return 5;
      default:   return 8;
    endcase
  endfunction

  function automatic int man_bits(fp_format_e fmt);
    case (fmt)
      FP32:    return 23;
      FP64:    return 52;
      FP16:    return 10;
      FP8:     return 2;
      default: return 7;
    endcase
  endfunction

  function automatic int fp_width(fp_format_e fmt);
    return 1 + exp_bits(fmt) + man_bits(fmt);
  endfunction
endpackage

// Mixed-format multiply: exact significand product, normalise, single rounding step.
module fp_mul #(
  parameter fpnew_pkg::fp_format_e FmtA   = fpnew_pkg::FP16,
  parameter fpnew_pkg::fp_format_e FmtB   = fpnew_pkg::FP16,
  parameter fpnew_pkg::fp_format_e FmtOut = fpnew_pkg::FP32,
  parameter fpnew_pkg::roundmode_e Rnd    = fpnew_pkg::RNE,
  localparam int WA = fpnew_pkg::fp_width(FmtA),
  localparam int WB = fpnew_pkg::fp_width(FmtB),
  localparam int WO = fpnew_pkg::fp_width(FmtOut)
) (
  input  logic [WA-1:0] operand_a,
  input  logic [WB-1:0] operand_b,
  output logic [WO-1:0] result
);
  localparam int EA = fpnew_pkg::exp_bits(FmtA),   MA = fpnew_pkg::man_bits(FmtA);
  localparam int EB = fpnew_pkg::exp_bits(FmtB),   MB = fpnew_pkg::man_bits(FmtB);
  localparam int EO = fpnew_pkg::exp_bits(FmtOut), MO = fpnew_pkg::man_bits(FmtOut);
  localparam int BiasA = 2**(EA-1) - 1, BiasB = 2**(EB-1) - 1, BiasO = 2**(EO-1) - 1;
  localparam int PW = MA + MB + 2;
  localparam int SW = PW + MO + 3;
  localparam int EMax = 2**EO - 1;

  logic sgn, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, rbit, stk, inc, ovf_max;
  logic [MA:0] sig_a;
  logic [MB:0] sig_b;
  logic [PW-1:0] prod;
  logic [SW-1:0] sig;
  logic [MO:0] keep;
  logic [EO+MO-1:0] mag;
  int exp_a, exp_b, lead, e, sh;

  always_comb begin
    sgn    = operand_a[WA-1] ^ operand_b[WB-1];
    a_zero = operand_a[WA-2:0] == '0;
    b_zero = operand_b[WB-2:0] == '0;
    a_inf  = &operand_a[WA-2 -: EA] && operand_a[MA-1:0] == '0;
    b_inf  = &operand_b[WB-2 -: EB] && operand_b[MB-1:0] == '0;
    a_nan  = &operand_a[WA-2 -: EA] && operand_a[MA-1:0] != '0;
    b_nan  = &operand_b[WB-2 -: EB] && operand_b[MB-1:0] != '0;
    sig_a  = {|operand_a[WA-2 -: EA], operand_a[MA-1:0]};
    sig_b  = {|operand_b[WB-2 -: EB], operand_b[MB-1:0]};
    exp_a  = (|operand_a[WA-2 -: EA] ? int'(operand_a[WA-2 -: EA]) : 1) - BiasA;
    exp_b  = (|operand_b[WB-2 -: EB] ? int'(operand_b[WB-2 -: EB]) : 1) - BiasB;
    prod   = PW'(sig_a) * PW'(sig_b);
    lead   = 0;
    for (int i = 0; i < PW; i++) if (prod[i]) lead = i;
    // e is the biased output exponent of the leading one; below 1 means subnormal result
    e   = exp_a + exp_b - MA - MB + lead + BiasO;
    sig = SW'(prod) << (SW - 1 - lead);
    sh  = (e < 1) ? 1 - e : 0;
    stk = 1'b0;
    for (int i = 0; i < SW; i++) if (i < sh && sig[i]) stk = 1'b1;
    sig  = (sh >= SW) ? '0 : sig >> sh;
    if (e < 1) e = 0;
    keep = sig[SW-1 -: MO+1];
    rbit = sig[SW-MO-2];
    stk  = stk | (|sig[SW-MO-3:0]);
    case (Rnd)
      fpnew_pkg::RNE: inc = rbit & (stk | keep[0]);
      fpnew_pkg::RTZ: inc = 1'b0;
      fpnew_pkg::RDN: inc = sgn & (rbit | stk);
      fpnew_pkg::RUP: inc = ~sgn & (rbit | stk);
      default:        inc = rbit;
    endcase
    ovf_max = (Rnd == fpnew_pkg::RTZ) || (Rnd == fpnew_pkg::RDN && !sgn) || (Rnd == fpnew_pkg::RUP && sgn);
    // rounding carry ripples from mantissa into exponent, covering subnormal->normal too
    mag = {EO'(e), keep[MO-1:0]} + (EO+MO)'(inc);
    if (e >= EMax || &mag[EO+MO-1 -: EO])
      mag = ovf_max ? {EO'(EMax - 1), {MO{1'b1}}} : {{EO{1'b1}}, {MO{1'b0}}};
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      result = {1'b0, {EO{1'b1}}, 1'b1, {(MO-1){1'b0}}};
    else if (a_inf || b_inf)
      result = {sgn, {EO{1'b1}}, {MO{1'b0}}};
    else if (a_zero || b_zero)
      result = {sgn, {(WO-1){1'b0}}};
    else
      result = {sgn, mag};
  end
endmodule

// One response slot: load on grant, clear when drained without a refill.
module fp_mul_rr_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         grant,
  input  logic         drain,
  input  logic [W-1:0] result,
  output logic         vld,
  output logic [W-1:0] data
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      data <= '0;
    end else if (grant) begin
      vld  <= 1'b1;
      data <= result;
    end else if (drain) begin
      vld  <= 1'b0;
    end
  end
endmodule

module fp_mul_rr_sched #(
  parameter int NumReq = 2,
  parameter fpnew_pkg::fp_format_e FpFormat_a   = fpnew_pkg::fp_format_e'(2),
  parameter fpnew_pkg::fp_format_e FpFormat_b   = fpnew_pkg::fp_format_e'(2),
  parameter fpnew_pkg::fp_format_e FpFormat_out = fpnew_pkg::fp_format_e'(0),
  parameter fpnew_pkg::roundmode_e RndMode      = fpnew_pkg::roundmode_e'(0),
  localparam int WIDTH_a   = fpnew_pkg::fp_width(FpFormat_a),
  localparam int WIDTH_b   = fpnew_pkg::fp_width(FpFormat_b),
  localparam int WIDTH_out = fpnew_pkg::fp_width(FpFormat_out)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq*WIDTH_a-1:0]     req_a_i,
  input  logic [NumReq*WIDTH_b-1:0]     req_b_i,
  output logic [NumReq-1:0]             rsp_valid_o,
  input  logic [NumReq-1:0]             rsp_ready_i,
  output logic [NumReq*WIDTH_out-1:0]   rsp_result_o,
  input  logic                          cnt_clear_i,
  output logic [31:0]                   ops_cnt_o,
  output logic                          busy_o
);
  localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [PtrW-1:0] rr_ptr_q, ptr_nxt;
  logic [NumReq-1:0] elig, grant, rsp_valid_q;
  logic [NumReq-1:0][WIDTH_out-1:0] rsp_result_q;
  logic [WIDTH_a-1:0] op_a;
  logic [WIDTH_b-1:0] op_b;
  logic [WIDTH_out-1:0] mul_res;
  logic [31:0] ops_cnt_q;
  logic found;
  int idx;

  // a slot being drained this cycle can take a new result, so back-to-back streams are lossless
  always_comb begin
    elig    = req_valid_i & (~rsp_valid_q | rsp_ready_i);
    grant   = '0;
    found   = 1'b0;
    ptr_nxt = rr_ptr_q;
    op_a    = '0;
    op_b    = '0;
    idx     = 0;
    for (int k = 0; k < NumReq; k++) begin
      idx = (int'(rr_ptr_q) + k) % NumReq;
      if (!found && elig[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_nxt    = PtrW'((idx + 1) % NumReq);
        op_a       = req_a_i[idx*WIDTH_a +: WIDTH_a];
        op_b       = req_b_i[idx*WIDTH_b +: WIDTH_b];
      end
    end
  end

  fp_mul #(
    .FmtA(FpFormat_a), .FmtB(FpFormat_b), .FmtOut(FpFormat_out), .Rnd(RndMode)
  ) u_mul (
    .operand_a(op_a),
    .operand_b(op_b),
    .result   (mul_res)
  );

  for (genvar i = 0; i < NumReq; i++) begin : g_slot
    fp_mul_rr_slot #(.W(WIDTH_out)) u_slot (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .grant (grant[i]),
      .drain (rsp_ready_i[i]),
      .result(mul_res),
      .vld   (rsp_valid_q[i]),
      .data  (rsp_result_q[i])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q  <= '0;
      ops_cnt_q <= '0;
    end else begin
      rr_ptr_q <= ptr_nxt;
      if (cnt_clear_i)
        ops_cnt_q <= {31'd0, found};
      else if (found)
        ops_cnt_q <= ops_cnt_q + 32'd1;
    end
  end

  assign req_ready_o  = grant;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = rsp_result_q;
  assign ops_cnt_o    = ops_cnt_q;
  assign busy_o       = |rsp_valid_q;
endmodule

// File: tb/tb_fp_mul_rr_sched.sv
// Directed bench for fp_mul_rr_sched (2 requesters, FP16 x FP16 -> FP32).
module tb_fp_mul_rr_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [63:0] rsp_result;
  logic        cnt_clear = 1'b0, busy;
  logic [31:0] ops_cnt;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  fp_mul_rr_sched dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_result_o(rsp_result),
    .cnt_clear_i (cnt_clear),
    .ops_cnt_o   (ops_cnt),
    .busy_o      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [15:0] a0, input logic [15:0] b0,
                       input logic [15:0] a1, input logic [15:0] b1, input logic [1:0] rr);
    req_valid = v;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    rsp_ready = rr;
  endtask

  task automatic pulse_rst();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_result", rsp_result, 64'h0);
    chk("rst_ops", 64'(ops_cnt), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_ready", 64'(req_ready), 64'h0);
    #4 rst_n = 1'b1;
    tick();

    // single requester 1.0 * 2.0
    drive(2'b01, 16'h3C00, 16'h4000, 16'h0, 16'h0, 2'b11);
    #1 chk("single_ready", 64'(req_ready), 64'h1);
    tick();
    drive(2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00);
    chk("single_valid", 64'(rsp_valid), 64'h1);
    chk("single_res", 64'(rsp_result[31:0]), 64'h40000000);
    chk("single_ops", 64'(ops_cnt), 64'h1);
    chk("single_busy", 64'(busy), 64'h1);

    // fairness and sign, from a freshly reset pointer
    pulse_rst();
    drive(2'b11, 16'h3E00, 16'hC000, 16'h4000, 16'h4000, 2'b11);
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("fair_grant%0d", k), 64'(req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
      tick();
      if (k % 2 == 0) chk($sformatf("fair_res%0d", k), 64'(rsp_result[31:0]), 64'hC0400000);
      else            chk($sformatf("fair_res%0d", k), 64'(rsp_result[63:32]), 64'h40800000);
    end
    chk("fair_ops", 64'(ops_cnt), 64'h4);

    // back-pressure on requester 0
    drive(2'b01, 16'h3C00, 16'h4000, 16'h0, 16'h0, 2'b11);
    tick();
    drive(2'b11, 16'h3E00, 16'hC000, 16'h4000, 16'h4000, 2'b10);
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("bp_grant%0d", k), 64'(req_ready), 64'h2);
      tick();
      chk($sformatf("bp_hold%0d", k), 64'(rsp_result[31:0]), 64'h40000000);
      chk($sformatf("bp_valid%0d", k), 64'(rsp_valid), 64'h3);
      chk($sformatf("bp_res1_%0d", k), 64'(rsp_result[63:32]), 64'h40800000);
    end
    rsp_ready = 2'b11;
    #1 chk("bp_regrant", 64'(req_ready), 64'h1);
    tick();
    chk("bp_newres", 64'(rsp_result[31:0]), 64'hC0400000);

    // special and boundary values through requester 0
    drive(2'b01, 16'h7C00, 16'h0000, 16'h0, 16'h0, 2'b11);
    tick();
    chk("inf_x_zero", 64'(rsp_result[31:0]), 64'h7FC00000);
    drive(2'b01, 16'h0001, 16'h0001, 16'h0, 16'h0, 2'b11);
    tick();
    chk("subn_x_subn", 64'(rsp_result[31:0]), 64'h27800000);
    drive(2'b01, 16'h8000, 16'h3C00, 16'h0, 16'h0, 2'b11);
    tick();
    chk("negzero", 64'(rsp_result[31:0]), 64'h80000000);
    drive(2'b01, 16'h7BFF, 16'h7BFF, 16'h0, 16'h0, 2'b11);
    tick();
    chk("max_x_max", 64'(rsp_result[31:0]), 64'h4F7FC004);

    // counter clear and asynchronous reset
    drive(2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b11);
    pulse_rst();
    chk("cnt_after_rst", 64'(ops_cnt), 64'h0);
    drive(2'b01, 16'h3C00, 16'h4000, 16'h0, 16'h0, 2'b11);
    repeat (5) tick();
    chk("cnt_five", 64'(ops_cnt), 64'h5);
    cnt_clear = 1'b1;
    tick();
    chk("cnt_clr_grant", 64'(ops_cnt), 64'h1);
    req_valid = 2'b00;
    tick();
    chk("cnt_clr_alone", 64'(ops_cnt), 64'h0);
    cnt_clear = 1'b0;
    drive(2'b10, 16'h0, 16'h0, 16'h4000, 16'h4000, 2'b11);
    tick();
    drive(2'b01, 16'h3C00, 16'h4000, 16'h0, 16'h0, 2'b01);
    tick();
    chk("pre_rst_valid", 64'(rsp_valid), 64'h3);
    chk("pre_rst_ops", 64'(ops_cnt), 64'h2);
    drive(2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(rsp_valid), 64'h0);
    chk("mid_rst_ops", 64'(ops_cnt), 64'h0);
    chk("mid_rst_busy", 64'(busy), 64'h0);
    chk("mid_rst_result", rsp_result, 64'h0);
    #2 rst_n = 1'b1;
    drive(2'b11, 16'h3C00, 16'h4000, 16'h4000, 16'h4000, 2'b11);
    #1 chk("post_rst_grant", 64'(req_ready), 64'h1);
    tick();
    chk("post_rst_valid", 64'(rsp_valid), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
